// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path: FSM states,
// counter widths, well-known mouse command bytes and the parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } tx_state_e;

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned TMO_W   = 21;
    localparam int unsigned BIT_W   = 4;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] DEV_ACK      = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length debounce for one PS/2 line; emits the
// synchronized level and a one-cycle strobe on each accepted 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    localparam int unsigned         CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        // A new level is accepted only after FILTER_LEN consecutive differing samples.
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        fall_d = level_q & ~level_d;
    end

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= i_line;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign o_sync = sync_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// 8 data bits + parity + stop on device clock falls, then capture the ACK bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned RTS_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_PS2Clk,
    input  logic       i_PS2Data,
    input  logic [7:0] i_byte,
    input  logic       i_start,
    output logic       o_ps2clk_oe,
    output logic       o_ps2data_oe,
    output logic       o_busy,
    output logic       o_tx_active,
    output logic       o_done,
    output logic       o_ack_ok,
    output logic       o_error
);

    localparam logic [PHASE_W-1:0] INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RTS_LAST     = PHASE_W'(RTS_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0]   STOP_FALL    = BIT_W'(9);

    tx_state_e          state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [8:0]         shift_q, shift_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               ack_ok_q, ack_ok_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               data_meta_q, data_sync_q;

    logic clk_sync;
    logic clk_fall;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .i_line (i_PS2Clk),
        .o_sync (clk_sync),
        .o_fall (clk_fall)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (state_q inside {ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
            tmo_d = clk_fall ? '0 : tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (i_start) begin
                    shift_d  = {odd_parity(i_byte), i_byte};
                    phase_d  = '0;
                    clk_oe_d = 1'b1;
                    ack_ok_d = 1'b0;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (phase_q == INHIBIT_LAST) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_RTS;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            ST_RTS: begin
                if (phase_q == RTS_LAST) begin
                    clk_oe_d = 1'b0;
                    bit_d    = '0;
                    tmo_d    = '0;
                    state_d  = ST_SEND;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            ST_SEND: begin
                // Shift register feeds data bits then parity; refill with 1 = released.
                if (clk_fall) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == STOP_FALL) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[8:1]};
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    bit_d    = bit_q + BIT_W'(1);
                    ack_ok_d = ~data_sync_q;
                    state_d  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A silent device aborts the transfer; lines are freed on the same edge.
        if ((state_q inside {ST_SEND, ST_ACK, ST_WAIT_IDLE}) && (tmo_q == TMO_LAST)) begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            tmo_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ack_ok_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ack_ok_q    <= ack_ok_d;
            done_q      <= done_d;
            error_q     <= error_d;
            data_meta_q <= i_PS2Data;
            data_sync_q <= data_meta_q;
        end
    end

    assign o_ps2clk_oe  = clk_oe_q;
    assign o_ps2data_oe = data_oe_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_tx_active  = o_busy;
    assign o_done       = done_q;
    assign o_ack_ok     = done_q & ack_ok_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: a device model clocks the frame out of the
// host, a scoreboard queue holds the expected outcome, a monitor checks each one.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 200;
    localparam int RTS = 16;
    localparam int TMO = 4000;
    localparam int FLT = 8;

    typedef struct {
        bit         is_err;
        bit         ack;
        logic [9:0] frame;
    } exp_t;

    logic       clk, rst_n;
    logic       dev_clk, dev_data;
    logic       ps2clk, ps2data;
    logic [7:0] i_byte;
    logic       i_start;
    logic       o_ps2clk_oe, o_ps2data_oe, o_busy, o_tx_active, o_done, o_ack_ok, o_error;

    exp_t       sb_q[$];
    logic [9:0] rx_bits;
    int         n_cmp = 0, n_bad = 0;
    int         n_events = 0, n_pushed = 0;
    int         cyc = 0, last_fall_cyc = 0;

    // Open-drain bus: whoever pulls low wins.
    assign ps2clk  = ~o_ps2clk_oe & dev_clk;
    assign ps2data = ~o_ps2data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_PS2Clk    (ps2clk),
        .i_PS2Data   (ps2data),
        .i_byte      (i_byte),
        .i_start     (i_start),
        .o_ps2clk_oe (o_ps2clk_oe),
        .o_ps2data_oe(o_ps2data_oe),
        .o_busy      (o_busy),
        .o_tx_active (o_tx_active),
        .o_done      (o_done),
        .o_ack_ok    (o_ack_ok),
        .o_error     (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame as the device should see it: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    // Device side: n_falls clock pulses, sampling the data line on each rising edge.
    task automatic run_device(input logic [7:0] b, input int half, input int n_falls,
                              input bit ack_low, input int glitch_at,
                              input int restart_at, input int reset_at);
        for (int k = 1; k <= n_falls; k++) begin
            wait_cycles(half / 2);
            if (k == glitch_at) begin
                dev_clk = 1'b0;
                wait_cycles(3);
                dev_clk = 1'b1;
            end
            if (k == 11 && ack_low) dev_data = 1'b0;
            wait_cycles(half / 2 + 2);
            dev_clk       = 1'b0;
            last_fall_cyc = cyc;
            if (k == reset_at) begin
                wait_cycles(20);
                rst_n = 1'b0;
                #1;
                check("reset_clk_oe", o_ps2clk_oe, 0);
                check("reset_data_oe", o_ps2data_oe, 0);
                check("reset_busy", o_busy, 0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                wait_cycles(5);
                rst_n = 1'b1;
                return;
            end
            if (k == restart_at) begin
                wait_cycles(4);
                i_start = 1'b1;
                i_byte  = ~b;
                wait_cycles(1);
                i_start = 1'b0;
                i_byte  = b;
                wait_cycles(half - 5);
            end else begin
                wait_cycles(half);
            end
            if (k <= 10) rx_bits[k-1] = ps2data;
            dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b, input bit ack_low, input int half,
                            input int n_falls, input int glitch_at,
                            input int restart_at, input int reset_at);
        exp_t e;
        int   edges = 0, inh = 0, rts = 0, budget;
        if (reset_at == 0) begin
            e.is_err = (n_falls < 11);
            e.ack    = ack_low;
            e.frame  = ref_frame(b);
            sb_q.push_back(e);
            n_pushed++;
        end
        rx_bits = '0;
        @(negedge clk);
        check("idle_before_start", o_busy, 0);
        i_start = 1'b1;
        i_byte  = b;
        while (edges < INH + RTS + 10) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                i_start = 1'b0;
                check("busy_after_start", o_busy, 1);
            end
            if (!o_ps2clk_oe) break;
            if (o_ps2data_oe) rts++;
            else inh++;
        end
        check("inhibit_len", inh, INH);
        check("rts_len", rts, RTS);
        check("clk_release_latency", edges, 1 + INH + RTS);
        check("start_bit_driven", o_ps2data_oe, 1);
        run_device(b, half, n_falls, ack_low, glitch_at, restart_at, reset_at);
        budget = TMO + 500;
        while (o_busy && budget > 0) begin
            wait_cycles(1);
            budget--;
        end
        check("busy_cleared", o_busy, 0);
        wait_cycles(10);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports an outcome.
    initial begin
        exp_t e;
        int   dt;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("tx_active_eq_busy", o_tx_active, o_busy);
                if (o_done || o_error) begin
                    n_events++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_event", {o_done, o_error}, 2'b00);
                    end else begin
                        e = sb_q.pop_front();
                        check("error_flag", o_error, e.is_err);
                        check("done_flag", o_done, !e.is_err);
                        if (e.is_err) begin
                            dt = cyc - last_fall_cyc;
                            check("timeout_window", (dt >= TMO) && (dt <= TMO + 20), 1);
                            check("err_clk_oe", o_ps2clk_oe, 0);
                            check("err_data_oe", o_ps2data_oe, 0);
                            check("err_busy", o_busy, 0);
                        end else begin
                            check("ack_ok", o_ack_ok, e.ack);
                            check("frame", rx_bits, e.frame);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        i_start  = 1'b0;
        i_byte   = 8'h00;
        wait_cycles(3);
        #1;
        check("rst_clk_oe", o_ps2clk_oe, 0);
        check("rst_data_oe", o_ps2data_oe, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_ack_ok", o_ack_ok, 0);
        check("rst_error", o_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(20);

        send_cmd(CMD_ENABLE,   1'b1, 40, 11, 0, 0, 0);
        send_cmd(CMD_RESET,    1'b0, 40, 11, 0, 0, 0);
        send_cmd(CMD_SET_RATE, 1'b1, 40, 5,  0, 0, 0);
        send_cmd(8'h3C,        1'b1, 36, 11, 0, 3, 0);
        send_cmd(8'hA5,        1'b1, 36, 11, 6, 0, 0);
        send_cmd(CMD_ENABLE,   1'b1, 40, 11, 0, 0, 4);
        send_cmd(CMD_ENABLE,   1'b1, 40, 11, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            send_cmd(8'($urandom), 1'($urandom), $urandom_range(30, 50), 11, 0, 0, 0);
        end

        wait_cycles(20);
        check("events_seen", n_events, n_pushed);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
